// File: rtl/jtframe_credits_vram_arb_pkg.sv
// Shared types for the credits VRAM arbiter: FSM states, requester select
// and the round-robin winner function.
package jtframe_credits_vram_arb_pkg;

    localparam int CRED_AW = 10;
    localparam int CRED_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_CLEAR = 3'd4
    } arb_state_t;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } req_sel_t;

    // With both requesters active the pointer decides; otherwise whoever asks wins.
    function automatic req_sel_t pick_winner(input logic a_req, input logic b_req,
                                             input req_sel_t rr);
        req_sel_t sel;
        if (a_req && b_req) begin
            sel = rr;
        end else if (b_req) begin
            sel = SEL_B;
        end else begin
            sel = SEL_A;
        end
        return sel;
    endfunction

endpackage

// File: rtl/jtframe_credits_vram_arb_if.sv
// Bundle of requester handshakes, clear control and the VRAM port seen by the arbiter.
interface jtframe_credits_vram_arb_if #(
    parameter int AW = jtframe_credits_vram_arb_pkg::CRED_AW,
    parameter int DW = jtframe_credits_vram_arb_pkg::CRED_DW
);

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          a_ack;
    logic [DW-1:0] a_dout;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din;
    logic          b_ack;
    logic [DW-1:0] b_dout;

    logic          clr_start;
    logic [DW-1:0] clr_data;
    logic          clr_busy;

    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_din;
    logic          vram_we;
    logic [DW-1:0] vram_dout;

    modport slave (
        input  a_req, a_we, a_addr, a_din,
        output a_ack, a_dout,
        input  b_req, b_we, b_addr, b_din,
        output b_ack, b_dout,
        input  clr_start, clr_data,
        output clr_busy,
        output vram_addr, vram_din, vram_we,
        input  vram_dout
    );

    modport master (
        output a_req, a_we, a_addr, a_din,
        input  a_ack, a_dout,
        output b_req, b_we, b_addr, b_din,
        input  b_ack, b_dout,
        output clr_start, clr_data,
        input  clr_busy,
        input  vram_addr, vram_din, vram_we,
        output vram_dout
    );

endinterface

// File: rtl/jtframe_credits_clr.sv
// Clear-engine address counter and busy flag; the counter stops at 2**AW
// instead of wrapping so a finished sweep can never restart by itself.
module jtframe_credits_clr #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          last,
    output logic [AW-1:0] addr_next
);

    localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] ONE       = {{AW{1'b0}}, 1'b1};

    logic [AW:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + ONE;
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

    assign last      = busy && (cnt == LAST_ADDR);
    assign addr_next = cnt[AW-1:0] + ONE[AW-1:0];

endmodule

// File: rtl/jtframe_credits_vram_arb.sv
// Credits/OSD VRAM arbiter: round-robin A/B access with fixed 3-cycle latency
// plus a full-memory clear engine that preempts new grants.
module jtframe_credits_vram_arb
    import jtframe_credits_vram_arb_pkg::*;
#(
    parameter int AW = CRED_AW,
    parameter int DW = CRED_DW
) (
    input  logic                      clk,
    input  logic                      rst,
    jtframe_credits_vram_arb_if.slave bus
);

    arb_state_t    state;
    arb_state_t    state_next;
    req_sel_t      rr;
    req_sel_t      cur_sel;
    req_sel_t      winner;
    logic          cur_we;
    logic          clr_pend;
    logic          clr_accept;
    logic          clr_go;
    logic          grant;
    logic          clr_busy;
    logic          clr_last;
    logic [AW-1:0] clr_addr_next;
    logic [DW-1:0] clr_fill;

    logic [AW-1:0] vram_addr_r;
    logic [DW-1:0] vram_din_r;
    logic          vram_we_r;
    logic          a_ack_r;
    logic          b_ack_r;
    logic [DW-1:0] a_dout_r;
    logic [DW-1:0] b_dout_r;

    jtframe_credits_clr #(.AW(AW)) u_clr (
        .clk       (clk),
        .rst       (rst),
        .start     (clr_go),
        .busy      (clr_busy),
        .last      (clr_last),
        .addr_next (clr_addr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A clear (fresh or pending) beats any requester, but only from IDLE.
    always_comb begin
        state_next = state;
        winner     = pick_winner(bus.a_req, bus.b_req, rr);
        clr_accept = bus.clr_start && !clr_busy && !clr_pend;
        clr_go     = (state == ST_IDLE) && (clr_pend || bus.clr_start);
        grant      = (state == ST_IDLE) && !clr_go && (bus.a_req || bus.b_req);
        case (state)
            ST_IDLE: begin
                if (clr_go) begin
                    state_next = ST_CLEAR;
                end else if (grant) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            ST_CLEAR: begin
                if (clr_last) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr          <= SEL_A;
            cur_sel     <= SEL_A;
            cur_we      <= 1'b0;
            clr_pend    <= 1'b0;
            clr_fill    <= '0;
            vram_addr_r <= '0;
            vram_din_r  <= '0;
            vram_we_r   <= 1'b0;
            a_ack_r     <= 1'b0;
            b_ack_r     <= 1'b0;
            a_dout_r    <= '0;
            b_dout_r    <= '0;
        end else begin
            vram_we_r <= 1'b0;
            a_ack_r   <= 1'b0;
            b_ack_r   <= 1'b0;

            if (clr_accept) begin
                clr_fill <= bus.clr_data;
            end
            if (clr_go) begin
                clr_pend <= 1'b0;
            end else if (clr_accept) begin
                clr_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (clr_go) begin
                        vram_addr_r <= '0;
                        vram_din_r  <= clr_pend ? clr_fill : bus.clr_data;
                        vram_we_r   <= 1'b1;
                    end else if (grant) begin
                        cur_sel <= winner;
                        rr      <= (winner == SEL_A) ? SEL_B : SEL_A;
                        if (winner == SEL_B) begin
                            cur_we      <= bus.b_we;
                            vram_addr_r <= bus.b_addr;
                            vram_din_r  <= bus.b_din;
                            vram_we_r   <= bus.b_we;
                        end else begin
                            cur_we      <= bus.a_we;
                            vram_addr_r <= bus.a_addr;
                            vram_din_r  <= bus.a_din;
                            vram_we_r   <= bus.a_we;
                        end
                    end
                end
                ST_WAIT: begin
                    // Registered RAM output is valid here, one cycle after ISSUE.
                    if (!cur_we) begin
                        if (cur_sel == SEL_B) begin
                            b_dout_r <= bus.vram_dout;
                        end else begin
                            a_dout_r <= bus.vram_dout;
                        end
                    end
                    a_ack_r <= (cur_sel == SEL_A);
                    b_ack_r <= (cur_sel == SEL_B);
                end
                ST_CLEAR: begin
                    if (!clr_last) begin
                        vram_addr_r <= clr_addr_next;
                        vram_we_r   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vram_addr = vram_addr_r;
    assign bus.vram_din  = vram_din_r;
    assign bus.vram_we   = vram_we_r;
    assign bus.a_ack     = a_ack_r;
    assign bus.b_ack     = b_ack_r;
    assign bus.a_dout    = a_dout_r;
    assign bus.b_dout    = b_dout_r;
    assign bus.clr_busy  = clr_busy;

endmodule

// File: tb/tb_jtframe_credits_vram_arb.sv
// Directed bench for the credits VRAM arbiter with a registered 1024x8 RAM model.
module tb_jtframe_credits_vram_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   we_count = 0;
    logic [7:0] mem [0:1023];

    jtframe_credits_vram_arb_if bus ();

    jtframe_credits_vram_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else begin
            if (bus.vram_we === 1'b1) mem[bus.vram_addr] <= bus.vram_din;
            bus.vram_dout <= mem[bus.vram_addr];
        end
        if (bus.vram_we === 1'b1) we_count <= we_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit on_b, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((on_b ? bus.b_ack : bus.a_ack) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_access(input bit on_b, input bit we, input logic [9:0] addr,
                             input logic [7:0] din, output int lat, output logic [7:0] dout);
        if (on_b) begin
            bus.b_we = we; bus.b_addr = addr; bus.b_din = din; bus.b_req = 1'b1;
        end else begin
            bus.a_we = we; bus.a_addr = addr; bus.a_din = din; bus.a_req = 1'b1;
        end
        wait_ack(on_b, lat);
        dout = on_b ? bus.b_dout : bus.a_dout;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int wc;
        rst = 1'b1;
        repeat (3) tick();
        mem_init = 1'b0;
        total++; if (bus.vram_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_vram_we: got %0b expected 0", bus.vram_we); end
        total++; if (bus.vram_addr !== 10'h000) begin bad++; $display("[TB] FAIL reset_vram_addr: got %0h expected 0", bus.vram_addr); end
        total++; if (bus.vram_din !== 8'h00) begin bad++; $display("[TB] FAIL reset_vram_din: got %0h expected 0", bus.vram_din); end
        total++; if ({bus.a_ack, bus.b_ack} !== 2'b00) begin bad++; $display("[TB] FAIL reset_acks: got %0b expected 00", {bus.a_ack, bus.b_ack}); end
        total++; if ({bus.a_dout, bus.b_dout} !== 16'h0000) begin bad++; $display("[TB] FAIL reset_douts: got %0h expected 0", {bus.a_dout, bus.b_dout}); end
        total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_clr_busy: got %0b expected 0", bus.clr_busy); end
        rst = 1'b0;
        wc = we_count;
        repeat (100) tick();
        total++; if (we_count - wc !== 0) begin bad++; $display("[TB] FAIL idle_we_pulses: got %0d expected 0", we_count - wc); end
    endtask

    task automatic test_write_read();
        int wc, lat;
        logic [7:0] d;
        wc = we_count;
        do_access(1'b0, 1'b1, 10'h005, 8'h41, lat, d);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL write_latency: got %0d expected 3", lat); end
        total++; if (we_count - wc !== 1) begin bad++; $display("[TB] FAIL write_we_pulses: got %0d expected 1", we_count - wc); end
        do_access(1'b0, 1'b0, 10'h005, 8'h00, lat, d);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL read_latency: got %0d expected 3", lat); end
        total++; if (d !== 8'h41) begin bad++; $display("[TB] FAIL read_data: got %0h expected 41", d); end
        total++; if (we_count - wc !== 1) begin bad++; $display("[TB] FAIL read_no_we: got %0d expected 1", we_count - wc); end
    endtask

    task automatic test_round_robin();
        int n, last_t;
        bit exp_b;
        n = 0; last_t = 0; exp_b = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.a_we = 1'b0; bus.a_addr = 10'h005;
        bus.b_we = 1'b0; bus.b_addr = 10'h006;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        for (int t = 1; t <= 200 && n < 20; t++) begin
            tick();
            if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
                total++; if ({bus.a_ack, bus.b_ack} !== {~exp_b, exp_b}) begin bad++; $display("[TB] FAIL rr_order[%0d]: got a=%0b b=%0b expected b=%0b", n, bus.a_ack, bus.b_ack, exp_b); end
                total++; if ((n == 0 ? t : t - last_t) !== (n == 0 ? 3 : 4)) begin bad++; $display("[TB] FAIL rr_spacing[%0d]: got %0d expected %0d", n, (n == 0 ? t : t - last_t), (n == 0 ? 3 : 4)); end
                if (!exp_b) begin
                    total++; if (bus.a_dout !== 8'h41) begin bad++; $display("[TB] FAIL rr_a_data[%0d]: got %0h expected 41", n, bus.a_dout); end
                end
                last_t = t;
                exp_b = ~exp_b;
                n++;
            end
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        total++; if (n !== 20) begin bad++; $display("[TB] FAIL rr_count: got %0d expected 20", n); end
        repeat (3) tick();
    endtask

    task automatic test_clear();
        int wc, busy_cycles, addr_err, exp_addr, lat;
        logic [7:0] d;
        logic [9:0] rb [0:2];
        rb[0] = 10'h000; rb[1] = 10'h200; rb[2] = 10'h3FF;
        busy_cycles = 0; addr_err = 0; exp_addr = 0;
        wc = we_count;
        bus.clr_data = 8'h20; bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 1100 && bus.clr_busy === 1'b1; i++) begin
            busy_cycles++;
            if (bus.vram_addr !== exp_addr[9:0] || bus.vram_we !== 1'b1) addr_err++;
            exp_addr++;
            if (i == 500) begin
                bus.clr_data = 8'h55; bus.clr_start = 1'b1;
            end else begin
                bus.clr_start = 1'b0;
            end
            tick();
        end
        bus.clr_start = 1'b0;
        total++; if (busy_cycles !== 1024) begin bad++; $display("[TB] FAIL clr_busy_len: got %0d expected 1024", busy_cycles); end
        total++; if (addr_err !== 0) begin bad++; $display("[TB] FAIL clr_addr_seq: got %0d bad cycles expected 0", addr_err); end
        total++; if (bus.vram_we !== 1'b0) begin bad++; $display("[TB] FAIL clr_we_drop: got %0b expected 0", bus.vram_we); end
        total++; if (we_count - wc !== 1024) begin bad++; $display("[TB] FAIL clr_writes: got %0d expected 1024", we_count - wc); end
        repeat (3) tick();
        total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_no_restart: got %0b expected 0", bus.clr_busy); end
        for (int k = 0; k < 3; k++) begin
            do_access(1'b0, 1'b0, rb[k], 8'h00, lat, d);
            total++; if (d !== 8'h20 || lat !== 3) begin bad++; $display("[TB] FAIL clr_readback[%0h]: got %0h lat %0d expected 20 lat 3", rb[k], d, lat); end
        end
    endtask

    task automatic test_clear_pending();
        int lat, waited;
        bus.b_we = 1'b0; bus.b_addr = 10'h010; bus.b_req = 1'b1;
        tick();
        bus.clr_data = 8'h33; bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0; bus.clr_data = 8'h99;
        tick();
        total++; if (bus.b_ack !== 1'b1) begin bad++; $display("[TB] FAIL pend_b_ack: got %0b expected 1", bus.b_ack); end
        total++; if (bus.b_dout !== 8'h20) begin bad++; $display("[TB] FAIL pend_b_data: got %0h expected 20", bus.b_dout); end
        bus.b_req = 1'b0;
        tick();
        tick();
        total++; if (bus.clr_busy !== 1'b1) begin bad++; $display("[TB] FAIL pend_clear_start: got %0b expected 1", bus.clr_busy); end
        repeat (10) tick();
        bus.a_we = 1'b0; bus.a_addr = 10'h010; bus.a_req = 1'b1;
        waited = 0;
        while (bus.clr_busy === 1'b1 && waited < 1100) begin
            tick();
            waited++;
        end
        total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL pend_clear_end: got %0b expected 0", bus.clr_busy); end
        wait_ack(1'b0, lat);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL stall_latency: got %0d expected 3", lat); end
        total++; if (bus.a_dout !== 8'h33) begin bad++; $display("[TB] FAIL stall_data: got %0h expected 33", bus.a_dout); end
        bus.a_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int acks, lat;
        logic [7:0] d;
        acks = 0;
        bus.a_we = 1'b0; bus.a_addr = 10'h3FF; bus.a_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++; if ({bus.vram_we, bus.a_ack, bus.clr_busy} !== 3'b000) begin bad++; $display("[TB] FAIL rst_wait_outputs: got %0b expected 000", {bus.vram_we, bus.a_ack, bus.clr_busy}); end
        total++; if (bus.a_dout !== 8'h00) begin bad++; $display("[TB] FAIL rst_wait_dout: got %0h expected 0", bus.a_dout); end
        bus.a_req = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("[TB] FAIL rst_no_ack: got %0d expected 0", acks); end
        bus.clr_data = 8'h77; bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 1100 && bus.vram_addr !== 10'h180; i++) tick();
        total++; if (bus.vram_addr !== 10'h180) begin bad++; $display("[TB] FAIL rst_clr_reach: got %0h expected 180", bus.vram_addr); end
        rst = 1'b1;
        #1;
        total++; if ({bus.clr_busy, bus.vram_we} !== 2'b00) begin bad++; $display("[TB] FAIL rst_clr_outputs: got %0b expected 00", {bus.clr_busy, bus.vram_we}); end
        total++; if (bus.vram_addr !== 10'h000) begin bad++; $display("[TB] FAIL rst_clr_addr: got %0h expected 0", bus.vram_addr); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_clr_stays_off: got %0b expected 0", bus.clr_busy); end
        do_access(1'b0, 1'b0, 10'h3FF, 8'h00, lat, d);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL post_rst_latency: got %0d expected 3", lat); end
        total++; if (d !== 8'h33) begin bad++; $display("[TB] FAIL post_rst_data: got %0h expected 33", d); end
    endtask

    initial begin
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_din = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_din = '0;
        bus.clr_start = 1'b0; bus.clr_data = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_clear();
        test_clear_pending();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
